// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the parametrised SPI slave and its read-data serialiser.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_WAIT_TX,
    ST_TX,
    ST_DONE
  } state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  function automatic int frame_w(input int payload_w);
    return payload_w + 2;
  endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// Parallel-load, MSB-first serialiser for the read-data phase; last flags the LSB cycle.
module spi_tx_shifter #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 load,
  input  logic                 shift,
  input  logic [PAYLOAD_W-1:0] din,
  output logic                 sout,
  output logic                 last
);

  localparam int CNT_W = $clog2(PAYLOAD_W);

  logic [PAYLOAD_W-1:0] shreg;
  logic [CNT_W-1:0]     cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clr) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= din;
      cnt   <= CNT_W'(PAYLOAD_W - 1);
    end else if (shift) begin
      shreg <= {shreg[PAYLOAD_W-2:0], 1'b0};
      cnt   <= cnt - CNT_W'(1);
    end
  end

  assign sout = shreg[PAYLOAD_W-1];
  assign last = (cnt == '0);

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: framed receive with command decode and a timed read-data reply.
// Build option: define SPI_SLAVE_ERR_EN to add the err strobe and its error detection.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | deselected; SS_n low starts a frame (no bit sampled)
// ST_RX      | shifting FRAME_W bits of MOSI, MSB first
// ST_WAIT_TX | read-data frame seen; waiting up to TX_TIMEOUT for tx_valid
// ST_TX      | serialising tx_data on MISO, one bit per cycle
// ST_DONE    | frame finished; waiting for SS_n to rise
module spi_slave_param
  import spi_slave_pkg::*;
#(
  parameter  int PAYLOAD_W  = 8,
  parameter  int TX_TIMEOUT = 15,
  localparam int FRAME_W    = frame_w(PAYLOAD_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [FRAME_W-1:0]   rx_data,
  output logic                 rx_valid,
  input  logic [PAYLOAD_W-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 busy
`ifdef SPI_SLAVE_ERR_EN
  ,
  output logic                 err
`endif
);

  localparam int BC_W = $clog2(FRAME_W);

  state_e             state, state_nxt;
  logic [BC_W-1:0]    bit_cnt;
  logic [FRAME_W-2:0] rx_shreg;
  logic [7:0]         tmr;
  logic [FRAME_W-1:0] frame_word;
  logic [1:0]         cmd_in;
  logic               shift_en, frame_done, go_idle, tmr_dec, timeout;
  logic               tx_load, tx_shift, tx_clr, tx_last, tx_sout;

  // The bit arriving on the current edge completes the frame without an extra cycle.
  assign frame_word = {rx_shreg, MOSI};
  assign cmd_in     = frame_word[FRAME_W-1 -: 2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    go_idle    = 1'b0;
    tmr_dec    = 1'b0;
    timeout    = 1'b0;
    tx_load    = 1'b0;
    tx_shift   = 1'b0;
    tx_clr     = 1'b0;
    case (state)
      ST_IDLE: if (!SS_n) state_nxt = ST_RX;
      ST_RX: begin
        if (SS_n) begin
          state_nxt = ST_IDLE;
          go_idle   = 1'b1;
        end else if (bit_cnt == BC_W'(FRAME_W - 1)) begin
          frame_done = 1'b1;
          case (cmd_in)
            CMD_RD_DATA:                          state_nxt = ST_WAIT_TX;
            CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR: state_nxt = ST_DONE;
          endcase
        end else begin
          shift_en = 1'b1;
        end
      end
      ST_WAIT_TX: begin
        if (SS_n) begin
          state_nxt = ST_IDLE;
          go_idle   = 1'b1;
        end else if (tx_valid) begin
          tx_load   = 1'b1;
          state_nxt = ST_TX;
        end else if (tmr == '0) begin
          timeout   = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_TX: begin
        if (SS_n) begin
          state_nxt = ST_IDLE;
          go_idle   = 1'b1;
        end else if (tx_last) begin
          tx_clr    = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          tx_shift = 1'b1;
        end
      end
      ST_DONE: begin
        if (SS_n) begin
          state_nxt = ST_IDLE;
          go_idle   = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        go_idle   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= '0;
      rx_shreg <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tmr      <= '0;
    end else begin
      rx_valid <= frame_done;
      if (go_idle || frame_done) begin
        bit_cnt  <= '0;
        rx_shreg <= '0;
      end else if (shift_en) begin
        bit_cnt  <= bit_cnt + BC_W'(1);
        rx_shreg <= frame_word[FRAME_W-2:0];
      end
      if (frame_done) rx_data <= frame_word;
      // Timer counts down the remaining WAIT_TX cycles; zero is the last one.
      if (frame_done && cmd_in == CMD_RD_DATA) tmr <= 8'(TX_TIMEOUT - 1);
      else if (tmr_dec)                         tmr <= tmr - 8'd1;
      else if (go_idle || timeout || tx_load)   tmr <= '0;
    end
  end

  spi_tx_shifter #(
    .PAYLOAD_W(PAYLOAD_W)
  ) u_tx_shifter (
    .clk  (clk),
    .rst  (rst),
    .clr  (tx_clr || go_idle),
    .load (tx_load),
    .shift(tx_shift),
    .din  (tx_data),
    .sout (tx_sout),
    .last (tx_last)
  );

  assign MISO = (state == ST_TX) && tx_sout;
  assign busy = (state != ST_IDLE);

`ifdef SPI_SLAVE_ERR_EN
  // read_flag only qualifies the read-data-without-read-address error.
  logic read_flag, abort, rd_miss;

  assign abort   = go_idle && (state inside {ST_RX, ST_WAIT_TX, ST_TX});
  assign rd_miss = frame_done && (cmd_in == CMD_RD_DATA) && !read_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_flag <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= abort || rd_miss || timeout;
      if (frame_done && cmd_in == CMD_RD_ADDR)      read_flag <= 1'b1;
      else if (frame_done && cmd_in == CMD_RD_DATA) read_flag <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/spi_slave_param.md
SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

Interface
REQ-001 Parameter PAYLOAD_W, default 8: payload bits per frame; legal range 4..32.
REQ-002 Parameter TX_TIMEOUT, default 15: maximum cycles to wait for tx_valid; legal range 1..255.
REQ-003 Derived constant FRAME_W = PAYLOAD_W+2: 2 command bits plus payload.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 SS_n  in  1  slave select, active low.
REQ-007 MOSI  in  1  serial input, MSB first, sampled on clk.
REQ-008 MISO  out  1  serial output, MSB first.
REQ-009 rx_data  out  FRAME_W  received frame: {cmd[1:0], payload}.
REQ-010 rx_valid  out  1  one-cycle strobe; rx_data is valid.
REQ-011 tx_data  in  PAYLOAD_W  read data from the memory side.
REQ-012 tx_valid  in  1  tx_data valid strobe.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 err  out  1  one-cycle error strobe; present only with SPI_SLAVE_ERR_EN.

Function
REQ-015 States SHALL be IDLE, RX, WAIT_TX, TX, DONE.
REQ-016 IDLE: SS_n=0 at edge E0 -> RX with bit counter 0; nothing is sampled at E0.
REQ-017 RX: edges E1..E_FW each shift MOSI into the frame, MSB first (FW = FRAME_W).
REQ-018 At edge E_FW, rx_data is loaded with the full frame, including the MOSI bit of that edge; rx_valid is high for exactly the next cycle.
REQ-019 Command codes: 00 write-address, 01 write-data, 10 read-address, 11 read-data.
REQ-020 After E_FW, cmd 11 -> WAIT_TX; any other cmd -> DONE.
REQ-021 read_flag is set on a completed cmd-10 frame and cleared on a completed cmd-11 frame.
REQ-022 WAIT_TX: the first edge with tx_valid=1 loads tx_data, drives MISO with tx_data[PAYLOAD_W-1], and moves to TX.
REQ-023 tx_valid is ignored in every state other than WAIT_TX.
REQ-024 WAIT_TX: if TX_TIMEOUT cycles pass without tx_valid -> DONE; MISO stays 0.
REQ-025 TX: each later edge presents the next lower bit, so each of the PAYLOAD_W bits is held for exactly one cycle; after the LSB cycle -> DONE and MISO=0.
REQ-026 DONE: hold until SS_n=1; MOSI is ignored; extra clocks produce no rx_valid.
REQ-027 SS_n=1 in any non-IDLE state -> IDLE on the next edge.
REQ-028 On that return to IDLE: counters and shift registers clear, MISO=0, no rx_valid for a partial frame, rx_data keeps its last value.
REQ-029 SS_n high and low on consecutive edges SHALL still pass through IDLE for at least one cycle.
REQ-030 MISO SHALL be 0 outside TX.

Reset
REQ-031 rst=1 asynchronously forces: state=IDLE, MISO=0, rx_data=0, rx_valid=0, busy=0, err=0, read_flag=0, all counters=0.
REQ-032 Reset mid-frame discards the frame; on rst release the first frame is decoded normally.

Configuration
REQ-033 Macro SPI_SLAVE_ERR_EN defined: the err port exists and pulses for one cycle on any of:
- SS_n abort in RX, WAIT_TX or TX;
- cmd 11 received with read_flag=0 (the transfer still proceeds);
- WAIT_TX timeout.
REQ-034 Macro undefined: no err port and no error logic; functional behaviour is otherwise identical.

Structure
REQ-035 Package spi_slave_pkg SHALL hold the state enum, the four command-code constants and the FRAME_W derivation function.
REQ-036 Sub-module spi_tx_shifter SHALL implement the parallel-load, MSB-first serialiser used in TX, parametrised by PAYLOAD_W.

Verification
REQ-037 Write-address: PAYLOAD_W=8, SS_n low, MOSI 00_1010_0101 -> rx_data=10'h0A5; rx_valid high one cycle, the cycle after the 10th sampled bit.
REQ-038 Read sequence: frame 10_0000_0011, then frame 11_0000_0000, tx_valid with tx_data=8'hC3 -> MISO carries 1,1,0,0,0,0,1,1 on 8 consecutive cycles, then 0; no err.
REQ-039 Abort: SS_n raised after 5 bits -> IDLE next edge, rx_valid never asserted, err=1 for one cycle when SPI_SLAVE_ERR_EN is defined.
REQ-040 Timeout: TX_TIMEOUT=4, cmd 11 frame, tx_valid held 0 -> DONE after 4 cycles, MISO=0; err pulse only when the macro is defined.
REQ-041 Parameter sweep: PAYLOAD_W=16, write-data frame 01_BEEF -> rx_data=18'h1BEEF.
REQ-042 Async reset: assert rst mid-TX -> MISO=0 and busy=0 with no clock edge; the next full frame decodes correctly.
